// File: rtl/mmio_perf_counters_pkg.sv
// Shared memory map for the performance-counter block: base address, register
// offsets and the read-address decode used by the CPU side and the benches.
package mmio_perf_counters_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [31:0] OFF_CYCLE   = 32'h0000_0010;
    localparam logic [31:0] OFF_INST    = 32'h0000_0014;
    localparam logic [31:0] OFF_CLEAR   = 32'h0000_0018;
    localparam logic [31:0] OFF_BRANCH  = 32'h0000_001C;
    localparam logic [31:0] OFF_CORRECT = 32'h0000_0020;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CYCLE,
        SEL_INST,
        SEL_BRANCH,
        SEL_CORRECT
    } cnt_sel_e;

    // Addresses below the base wrap to a huge offset and fall into SEL_NONE.
    function automatic cnt_sel_e decode_read(input logic [31:0] addr,
                                             input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        case (offset)
            OFF_CYCLE:   return SEL_CYCLE;
            OFF_INST:    return SEL_INST;
            OFF_BRANCH:  return SEL_BRANCH;
            OFF_CORRECT: return SEL_CORRECT;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_perf_counters_if.sv
// Memory-access-stage MMIO port: address, load/store strobes and the
// registered load response (hit flag and data).
interface mmio_perf_counters_if #(
    parameter int CNT_WIDTH = 32
);
    logic [31:0]          mmio_addr;
    logic                 mmio_re;
    logic                 mmio_we;
    logic                 hit;
    logic [CNT_WIDTH-1:0] rdata;

    modport master (
        output mmio_addr, mmio_re, mmio_we,
        input  hit, rdata
    );

    modport slave (
        input  mmio_addr, mmio_re, mmio_we,
        output hit, rdata
    );
endinterface

// File: rtl/mmio_perf_counters_perf_counter.sv
// Single free-running event counter with a synchronous clear that takes
// priority over the increment; wraps modulo 2^CNT_WIDTH.
module perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] value
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= value + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mmio_perf_counters.sv
// Memory-mapped cycle/instruction/branch/correct-prediction counters with a
// one-cycle registered read port and a write-triggered clear of all four.
module mmio_perf_counters
    import mmio_perf_counters_pkg::*;
#(
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_perf_counters_if.slave   bus,
    input  logic                  inst_retire,
    input  logic                  br_retire,
    input  logic                  br_correct
);

    logic                 clr;
    logic                 inc_inst;
    logic                 inc_branch;
    logic                 inc_correct;
    logic [CNT_WIDTH-1:0] cnt_cycle;
    logic [CNT_WIDTH-1:0] cnt_inst;
    logic [CNT_WIDTH-1:0] cnt_branch;
    logic [CNT_WIDTH-1:0] cnt_correct;
    cnt_sel_e             sel;
    logic [CNT_WIDTH-1:0] read_value;

    // Branch qualifiers only count when an instruction actually retires.
    assign clr         = bus.mmio_we && (bus.mmio_addr == MMIO_BASE + OFF_CLEAR);
    assign inc_inst    = inst_retire;
    assign inc_branch  = inst_retire && br_retire;
    assign inc_correct = inst_retire && br_retire && br_correct;

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (1'b1),
        .value (cnt_cycle)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_inst (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc_inst),
        .value (cnt_inst)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc_branch),
        .value (cnt_branch)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_correct (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc_correct),
        .value (cnt_correct)
    );

    assign sel = decode_read(bus.mmio_addr, MMIO_BASE);

    // NOTE: default assignment first so no path through the case leaves
    // read_value unassigned and infers a latch.
    always_comb begin
        read_value = '0;
        case (sel)
            SEL_CYCLE:   read_value = cnt_cycle;
            SEL_INST:    read_value = cnt_inst;
            SEL_BRANCH:  read_value = cnt_branch;
            SEL_CORRECT: read_value = cnt_correct;
            default:     read_value = '0;
        endcase
    end

    // Counter values are pre-edge here, so a read coinciding with a clear
    // returns the old count; with no load the response simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.hit   <= 1'b0;
            bus.rdata <= '0;
        end else if (bus.mmio_re) begin
            bus.hit   <= (sel != SEL_NONE);
            bus.rdata <= read_value;
        end
    end

endmodule
